// File: rtl/sdram_client_responder.sv
// Responder end of the SDRAM client port: runs client bursts word-by-word
// against the single-word controller port and arbitrates memory ownership
// with a priority master through a request/yield/grant handshake.
module sdram_client_responder #(
  parameter int BURST_LEN = 8
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [1:0]  i_Command,
  input  logic [21:0] i_Data_Address,
  input  logic [31:0] i_Data_Write,
  output logic [31:0] o_Data_Read,
  output logic        o_Data_Read_Valid,
  output logic        o_Data_Write_Done,
  output logic        o_SDRAM_Requested,
  input  logic        i_SDRAM_Yield,
  input  logic        i_Priority_Req,
  output logic        o_Priority_Grant,
  output logic        o_Mem_Req,
  output logic        o_Mem_We,
  output logic [21:0] o_Mem_Addr,
  output logic [31:0] o_Mem_Wdata,
  input  logic        i_Mem_Ack,
  input  logic [31:0] i_Mem_Rdata,
  output logic        o_Protocol_Error
);

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_READ    = 2'd1;
  localparam logic [1:0] CMD_WRITE   = 2'd2;
  localparam logic [1:0] CMD_ILLEGAL = 2'd3;
  localparam logic [7:0] CNT_LAST    = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_HANDOFF,
    S_GRANT
  } state_t;

  state_t      state, state_next;
  logic [1:0]  cmd_q;
  logic [7:0]  cnt;
  logic        latch_cmd, inc_cnt, set_err;
  logic        cmd_is_rw, last_word;

  assign cmd_is_rw = (i_Command == CMD_READ) || (i_Command == CMD_WRITE);
  assign last_word = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic plus the datapath control strobes it implies
  always_comb begin
    state_next = state;
    latch_cmd  = 1'b0;
    inc_cnt    = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_is_rw) begin
          // A client command takes precedence over a same-cycle priority request
          state_next = S_REQ;
          latch_cmd  = 1'b1;
        end else begin
          if (i_Command == CMD_ILLEGAL) set_err = 1'b1;
          if (i_Priority_Req) state_next = S_HANDOFF;
        end
      end
      S_REQ: begin
        if (i_Mem_Ack) state_next = S_RESP;
      end
      S_RESP: begin
        if (last_word) begin
          state_next = S_IDLE;
        end else if (i_Command != cmd_q) begin
          set_err    = 1'b1;
          state_next = S_IDLE;
        end else begin
          inc_cnt    = 1'b1;
          state_next = S_REQ;
        end
      end
      S_HANDOFF: begin
        if (i_Command != CMD_IDLE) set_err = 1'b1;
        if (i_SDRAM_Yield)        state_next = S_GRANT;
        else if (!i_Priority_Req) state_next = S_IDLE;
      end
      S_GRANT: begin
        if (!i_Priority_Req) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Latched command, word counter, read data, request and error flags
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cmd_q             <= CMD_IDLE;
      cnt               <= '0;
      o_Data_Read       <= '0;
      o_SDRAM_Requested <= 1'b0;
      o_Protocol_Error  <= 1'b0;
    end else begin
      if (latch_cmd) begin
        cmd_q <= i_Command;
        cnt   <= '0;
      end else if (inc_cnt) begin
        cnt <= cnt + 8'd1;
      end
      if (state == S_REQ && i_Mem_Ack && cmd_q == CMD_READ)
        o_Data_Read <= i_Mem_Rdata;
      // Looking at the next state lets the request drop in the same cycle the grant rises
      o_SDRAM_Requested <= i_Priority_Req && (state_next != S_GRANT);
      if (set_err) o_Protocol_Error <= 1'b1;
    end
  end

  // Outputs decoded from the current state and latched command
  always_comb begin
    o_Mem_Req         = (state == S_REQ);
    o_Data_Read_Valid = (state == S_RESP) && (cmd_q == CMD_READ);
    o_Data_Write_Done = (state == S_RESP) && (cmd_q == CMD_WRITE);
    o_Priority_Grant  = (state == S_GRANT);
    o_Mem_We          = (cmd_q == CMD_WRITE);
  end

  assign o_Mem_Addr  = i_Data_Address;
  assign o_Mem_Wdata = i_Data_Write;

endmodule
